// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port SRAM macro (active-low csb0/web0) between two
//   requesters. Port 0 is the UPDI command/loader side, port 1 the streaming
//   reader side. Exactly one access is in flight at a time; the SRAM control
//   pins are driven from registers.
//
//   Sequence per access: IDLE (arbitrate, drive command) -> ACCESS (SRAM
//   captures at the end of this cycle) -> RDATA (reads only, return dout0)
//   -> IDLE. Writes take 2 cycles, reads 3.
//
//   Optional feature macro: SRAM_ARB_RR_EN
//     defined   : round-robin on ties (grant the port that did not win last)
//     undefined : fixed priority, port 0 always wins ties
//
// Ports
//   i_clk, i_rst               clock (rising edge), async active-high reset
//   i_req0/1                   level request, held until the matching grant
//   i_we0/1                    1 = write, 0 = read
//   i_addr0/1, i_wdata0/1      address / write data, stable while requesting
//   o_gnt0/1                   one-cycle pulse: request accepted
//   o_rdata0/1, o_rvalid0/1    read return data and one-cycle valid pulse
//   o_busy                     an access is in flight
//   csb0, web0, addr0, din0    SRAM command (csb0/web0 active low)
//   dout0                      SRAM read data, valid the cycle after capture
module sram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0,
  input  logic                  i_we0,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  output logic                  o_gnt0,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  output logic                  o_rvalid0,
  input  logic                  i_req1,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic                  o_gnt1,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic                  o_rvalid1,
  output logic                  o_busy,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic                  csb_reg, csb_next;
  logic                  web_reg, web_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] din_reg, din_next;
  logic [1:0]            gnt_reg, gnt_next;
  logic [1:0]            rvalid_reg, rvalid_next;
  logic                  owner_reg, owner_next;
  logic                  op_we_reg, op_we_next;

  logic                  any_req;
  logic                  winner;
  logic                  win_we;

`ifdef SRAM_ARB_RR_EN
  // Index of the port granted most recently; resets to 1 so port 0 takes
  // the first tie.
  logic                  last_reg, last_next;
`endif

  // Winner selection. With a single requester it simply wins; on a tie the
  // configured policy decides.
  always_comb begin
    any_req = i_req0 | i_req1;
`ifdef SRAM_ARB_RR_EN
    winner  = (i_req0 && i_req1) ? ~last_reg : ~i_req0;
`else
    winner  = ~i_req0;
`endif
    win_we  = winner ? i_we1 : i_we0;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_next  = state_reg;
    csb_next    = 1'b1;
    web_next    = 1'b1;
    addr_next   = addr_reg;
    din_next    = din_reg;
    gnt_next    = 2'b00;
    rvalid_next = 2'b00;
    owner_next  = owner_reg;
    op_we_next  = op_we_reg;
`ifdef SRAM_ARB_RR_EN
    last_next   = last_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          csb_next         = 1'b0;
          web_next         = ~win_we;
          addr_next        = winner ? i_addr1 : i_addr0;
          din_next         = winner ? i_wdata1 : i_wdata0;
          gnt_next[winner] = 1'b1;
          owner_next       = winner;
          op_we_next       = win_we;
`ifdef SRAM_ARB_RR_EN
          last_next        = winner;
`endif
          state_next       = ACCESS;
        end
      end
      ACCESS: begin
        // Command is captured by the SRAM at the end of this cycle.
        state_next = op_we_reg ? IDLE : RDATA;
      end
      RDATA: begin
        rvalid_next[owner_reg] = 1'b1;
        state_next             = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg  <= IDLE;
      csb_reg    <= 1'b1;
      web_reg    <= 1'b1;
      addr_reg   <= '0;
      din_reg    <= '0;
      gnt_reg    <= 2'b00;
      rvalid_reg <= 2'b00;
      owner_reg  <= 1'b0;
      op_we_reg  <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      last_reg   <= 1'b1;
`endif
    end else begin
      state_reg  <= state_next;
      csb_reg    <= csb_next;
      web_reg    <= web_next;
      addr_reg   <= addr_next;
      din_reg    <= din_next;
      gnt_reg    <= gnt_next;
      rvalid_reg <= rvalid_next;
      owner_reg  <= owner_next;
      op_we_reg  <= op_we_next;
`ifdef SRAM_ARB_RR_EN
      last_reg   <= last_next;
`endif
    end
  end

  // Per-port read-return registers: only the owner's copy is loaded, the
  // other port keeps whatever it last returned.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [DATA_WIDTH-1:0] rdata_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        rdata_reg <= '0;
      end else if (state_reg == RDATA && owner_reg == 1'(gi)) begin
        rdata_reg <= dout0;
      end
    end
  end

  assign o_rdata0  = g_port[0].rdata_reg;
  assign o_rdata1  = g_port[1].rdata_reg;
  assign o_gnt0    = gnt_reg[0];
  assign o_gnt1    = gnt_reg[1];
  assign o_rvalid0 = rvalid_reg[0];
  assign o_rvalid1 = rvalid_reg[1];
  assign o_busy    = (state_reg != IDLE);
  assign csb0      = csb_reg;
  assign web0      = web_reg;
  assign addr0     = addr_reg;
  assign din0      = din_reg;

endmodule
